// File: rtl/pipelined_subtractor_16bit.sv
// Two-stage pipelined subtractor: D = X + ~Y + 1, low part in stage 1, high part in stage 2.
// Optional macro SUB_SATURATE_EN clamps D to the signed range when V is set.
module pipelined_subtractor_16bit #(
    parameter int WIDTH = 16,
    parameter int SPLIT = 8
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] D,
    output logic             Bout,
    output logic             V,
    output logic             Z
);
    localparam int HW = WIDTH - SPLIT;

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; ready depends only on pipeline occupancy and out_ready, never on in_valid.
    logic s1_valid;
    logic s2_valid;
    logic s1_take;
    logic s2_take;

    logic [SPLIT-1:0] s1_low;
    logic             s1_c;
    logic [HW-1:0]    s1_xh;
    logic [HW-1:0]    s1_yh;

    logic [SPLIT:0]   low_sum;
    logic [HW:0]      high_sum;
    logic [WIDTH-1:0] raw_d;
    logic [WIDTH-1:0] final_d;
    logic             x_msb;
    logic             y_msb;
    logic             raw_v;

    assign s2_take   = !s2_valid || out_ready;
    assign s1_take   = !s1_valid || s2_take;
    assign in_ready  = s1_take;
    assign out_valid = s2_valid;

    assign low_sum  = {1'b0, X[SPLIT-1:0]} + {1'b0, ~Y[SPLIT-1:0]} + {{SPLIT{1'b0}}, 1'b1};
    assign high_sum = {1'b0, s1_xh} + {1'b0, ~s1_yh} + {{HW{1'b0}}, s1_c};
    assign raw_d    = {high_sum[HW-1:0], s1_low};
    assign x_msb    = s1_xh[HW-1];
    assign y_msb    = s1_yh[HW-1];
    assign raw_v    = (x_msb != y_msb) && (raw_d[WIDTH-1] != x_msb);

`ifdef SUB_SATURATE_EN
    // Positive minus negative overflows upward, so clamp to the largest positive value.
    always_comb begin
        final_d = raw_d;
        if (raw_v) begin
            final_d = x_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    assign final_d = raw_d;
`endif

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            s1_valid <= 1'b0;
            s1_low   <= '0;
            s1_c     <= 1'b0;
            s1_xh    <= '0;
            s1_yh    <= '0;
        end else if (s1_take) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_low <= low_sum[SPLIT-1:0];
                s1_c   <= low_sum[SPLIT];
                s1_xh  <= X[WIDTH-1:SPLIT];
                s1_yh  <= Y[WIDTH-1:SPLIT];
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            s2_valid <= 1'b0;
            D        <= '0;
            Bout     <= 1'b0;
            V        <= 1'b0;
            Z        <= 1'b0;
        end else if (s2_take) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                D    <= final_d;
                Bout <= ~high_sum[HW];
                V    <= raw_v;
                Z    <= (final_d == '0);
            end
        end
    end

endmodule

// File: tb/tb_pipelined_subtractor_16bit.sv
// Self-checking bench for pipelined_subtractor_16bit: directed literal vectors,
// backpressure, random streaming against an arithmetic reference, and mid-flight reset.
module tb_pipelined_subtractor_16bit;
    localparam int W = 19;

    logic        Clk;
    logic        Rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] X;
    logic [15:0] Y;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] D;
    logic        Bout;
    logic        V;
    logic        Z;

    int checks = 0;
    int errors = 0;
    int n_out  = 0;

    logic [W-1:0] exp_q[$];

    logic         held;
    logic [W-1:0] held_val;

    pipelined_subtractor_16bit dut (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .X        (X),
        .Y        (Y),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .D        (D),
        .Bout     (Bout),
        .V        (V),
        .Z        (Z)
    );

    // ---------------- clock / reset ----------------
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // ---------------- reference model ----------------
    function automatic logic [W-1:0] model(input logic [15:0] x, input logic [15:0] y);
        int          sx;
        int          sy;
        int          sd;
        logic [15:0] d;
        logic        b;
        logic        v;
        sx = $signed(x);
        sy = $signed(y);
        sd = sx - sy;
        d  = x - y;
        b  = (x < y);
        v  = (sd > 32767) || (sd < -32768);
`ifdef SUB_SATURATE_EN
        if (v) d = (sd > 0) ? 16'h7FFF : 16'h8000;
`endif
        return {b, v, (d == 16'h0000), d};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard / compare process ----------------
    always @(negedge Clk) begin
        if (!Rst_n) begin
            held = 1'b0;
        end else begin
            if (held && out_valid) check("stall_hold", {13'd0, Bout, V, Z, D}, {13'd0, held_val});
            if (out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    check("spurious_output", 32'd1, 32'd0);
                end else begin
                    check("result", {13'd0, Bout, V, Z, D}, {13'd0, exp_q.pop_front()});
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(X, Y));
            held     = out_valid && !out_ready;
            held_val = {Bout, V, Z, D};
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic send(input logic [15:0] x, input logic [15:0] y);
        logic acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        X        = x;
        Y        = y;
        for (int i = 0; i < 200; i++) begin
            @(negedge Clk);
            if (in_ready) begin
                acc = 1'b1;
                break;
            end
        end
        step();
        in_valid = 1'b0;
        if (!acc) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic directed(input string name, input logic [15:0] x, input logic [15:0] y,
                            input logic [15:0] ed, input logic eb, input logic ev, input logic ez);
        out_ready = 1'b1;
        send(x, y);
        check({name, "_early_valid"}, {31'd0, out_valid}, 32'd0);
        step();
        check({name, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({name, "_D"}, {16'd0, D}, {16'd0, ed});
        check({name, "_flags"}, {29'd0, Bout, V, Z}, {29'd0, eb, ev, ez});
        step();
        step();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int          idx;
        int          nb;
        int          sent;
        int          base_out;
        int          ov_count;
        logic        acc;
        logic [15:0] got[8];
        int          gc[8];

        Rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        X         = '0;
        Y         = '0;
        held      = 1'b0;
        held_val  = '0;

        repeat (3) step();
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_D", {16'd0, D}, 32'd0);
        check("reset_flags", {29'd0, Bout, V, Z}, 32'd0);
        Rst_n = 1'b1;
        step();
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);

        // Directed vectors with hand-computed results
        directed("basic",      16'h1234, 16'h0234, 16'h1000, 1'b0, 1'b0, 1'b0);
        directed("split",      16'h0100, 16'h0001, 16'h00FF, 1'b0, 1'b0, 1'b0);
        directed("borrow",     16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        directed("zero",       16'hABCD, 16'hABCD, 16'h0000, 1'b0, 1'b0, 1'b1);
        directed("split_low",  16'h0100, 16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0);
`ifdef SUB_SATURATE_EN
        directed("ovf_neg",    16'h8000, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0);
        directed("ovf_pos",    16'h7FFF, 16'hFFFF, 16'h7FFF, 1'b1, 1'b1, 1'b0);
`else
        directed("ovf_neg",    16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b0);
        directed("ovf_pos",    16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b1, 1'b0);
`endif

        // Backpressure: four back-to-back offers with the consumer stalled
        out_ready = 1'b0;
        idx       = 0;
        in_valid  = 1'b1;
        X         = 16'd5;
        Y         = 16'd1;
        for (int c = 0; c < 6; c++) begin
            @(negedge Clk);
            if (in_valid && in_ready) idx++;
            step();
            if (idx < 4) X = 16'(5 + idx);
            else in_valid = 1'b0;
        end
        check("bp_accepted", idx, 2);
        check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        check("bp_out_valid", {31'd0, out_valid}, 32'd1);
        check("bp_D_held", {16'd0, D}, 32'h0004);

        out_ready = 1'b1;
        nb        = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge Clk);
            if (out_valid && out_ready && nb < 8) begin
                got[nb] = D;
                gc[nb]  = c;
                nb++;
            end
            if (in_valid && in_ready) idx++;
            step();
            if (idx < 4) X = 16'(5 + idx);
            else in_valid = 1'b0;
        end
        check("bp_count", nb, 4);
        for (int i = 0; i < 4; i++) begin
            check("bp_order", {16'd0, got[i]}, 32'(4 + i));
            check("bp_cadence", gc[i], i);
        end

        // Random streaming with toggling valid/ready
        sent     = 0;
        base_out = n_out;
        acc      = 1'b1;
        in_valid = 1'b0;
        for (int c = 0; c < 2000 && sent < 100; c++) begin
            @(negedge Clk);
            acc = !in_valid || in_ready;
            if (in_valid && in_ready) sent++;
            step();
            out_ready = ($urandom_range(0, 3) != 0);
            if (acc) begin
                if (sent < 100 && $urandom_range(0, 2) != 0) begin
                    in_valid = 1'b1;
                    case ($urandom_range(0, 3))
                        0:       begin X = 16'h8000; Y = 16'(    $urandom_range(0, 65535)); end
                        1:       begin X = 16'(      $urandom_range(0, 65535)); Y = X; end
                        default: begin X = 16'(      $urandom_range(0, 65535));
                                       Y = 16'(      $urandom_range(0, 65535)); end
                    endcase
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 50 && exp_q.size() != 0; c++) step();
        check("stream_sent", sent, 100);
        check("stream_drained", exp_q.size(), 0);
        check("stream_outputs", n_out - base_out, 100);

        // Reset mid-flight
        out_ready = 1'b0;
        send(16'd1, 16'd1);
        send(16'd2, 16'd1);
        check("mid_inflight", {31'd0, out_valid}, 32'd1);
        #2;
        Rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("mid_reset_valid", {31'd0, out_valid}, 32'd0);
        check("mid_reset_D", {16'd0, D}, 32'd0);
        repeat (2) step();
        Rst_n = 1'b1;
        step();
        check("mid_release_in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        ov_count  = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge Clk);
            if (out_valid) ov_count++;
            step();
        end
        check("mid_no_stale", ov_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipelined_subtractor_16bit.md
Name: pipelined_subtractor_16bit

Overview:
- Two-stage pipelined 16-bit subtractor. Computes D = X - Y as X + ~Y + 1 and reports borrow, signed-overflow and zero flags.
- It is the inverse operation to the team's 16-bit carry-lookahead adder.
- The low byte is resolved in stage 1; its carry is registered and consumed by the high byte in stage 2.
- Sits between an operand producer and a result consumer. Both sides use valid/ready handshakes with full backpressure.

Parameters:
- WIDTH, 16, operand and result width; only 16 is supported.
- SPLIT, 8, bit position of the stage 1 / stage 2 boundary; must satisfy 0 < SPLIT < WIDTH.

Ports:
- Clk  input  1  rising-edge clock.
- Rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  X/Y operands valid.
- in_ready  output  1  block can accept an operand pair this cycle.
- X  input  16  minuend.
- Y  input  16  subtrahend.
- out_valid  output  1  D and flags valid.
- out_ready  input  1  consumer accepts the result this cycle.
- D  output  16  difference, X - Y mod 2^16.
- Bout  output  1  borrow out: 1 iff X < Y unsigned (inverted carry out of bit 15).
- V  output  1  signed overflow: X[15] != Y[15] and raw D[15] != X[15].
- Z  output  1  1 iff D == 16'h0000, evaluated on the final (possibly saturated) D.

Behaviour:
- Reset (Rst_n low, asynchronous): s1_valid=0, s2_valid=0, out_valid=0, D=0, Bout=0, V=0, Z=0, all stage registers 0. in_ready goes to 1 once reset is released.
- Handshakes:
  - Input transfer occurs when in_valid and in_ready are both high at a rising edge.
  - Output transfer occurs when out_valid and out_ready are both high at a rising edge.
  - X and Y are sampled only on an input transfer.
- Stage 1 register, loaded on input transfer:
  - low result = X[SPLIT-1:0] + ~Y[SPLIT-1:0] + 1.
  - c_split = carry out of bit SPLIT-1.
  - X and Y high parts, X[15], Y[15].
- Stage 2 register, loaded on stage advance:
  - high result = Xh + ~Yh + c_split.
  - D = {high, low}; Bout = ~carry out of bit 15; V per the formula above; Z.
- Advance rules:
  - s2_take = !s2_valid || out_ready.
  - s1_take = !s1_valid || s2_take.
  - in_ready = s1_take. This is combinational from out_ready; no combinational path from in_valid to in_ready.
  - s2_valid is set when s1_valid && s2_take, and cleared on output transfer with no refill.
- Latency: 2 cycles from input transfer to out_valid when out_ready is held high. Throughput is one result per cycle.
- Stall: with out_ready=0, D and flags are held stable while out_valid=1. Stage 1 holds one more item, then in_ready drops. No item is lost, duplicated or reordered.
- Simultaneous input transfer and output transfer in the same cycle: both occur and the pipeline stays full.
- Carry across the split is exact: results match a flat 16-bit subtract for all operands.
- Reset asserted mid-operation discards all in-flight items immediately. No output transfer may follow for them.

Optional Feature:
- Macro: SUB_SATURATE_EN.
- Defined: when V=1, D is clamped. X[15]=0 (positive minus negative) gives 16'h7FFF; X[15]=1 gives 16'h8000. V and Bout still report the raw result; Z uses the clamped D.
- Undefined: D is the wrapped modulo-2^16 result. The port list is identical either way.

Test Plan:
- Basic: X=16'h1234, Y=16'h0234, out_ready=1 -> out_valid exactly 2 cycles after transfer; D=16'h1000, Bout=0, V=0, Z=0.
- Borrow across split: X=16'h0100, Y=16'h0001 -> D=16'h00FF, Bout=0. Then X=16'h0000, Y=16'h0001 -> D=16'hFFFF, Bout=1, V=0. Then X=Y=16'hABCD -> D=0, Z=1.
- Overflow: X=16'h8000, Y=16'h0001 -> V=1, Bout=0; D=16'h7FFF (wrap) or 16'h8000 (SUB_SATURATE_EN). X=16'h7FFF, Y=16'hFFFF -> V=1, Bout=1; D=16'h8000 (wrap) or 16'h7FFF (saturate).
- Backpressure:
  - Stimulus: out_ready=0, offer 4 back-to-back pairs (0x0005-0x0001, 0x0006-0x0001, 0x0007-0x0001, 0x0008-0x0001).
  - Response: exactly 2 accepted, then in_ready=0 and D=0x0004 held stable.
  - Then raise out_ready: results 0x0004, 0x0005, 0x0006, 0x0007 appear in order, one per cycle.
- Streaming: 100 random pairs with random in_valid/out_ready toggling -> every result matches the reference X-Y and flags, in order, with no drops or duplicates.
- Reset mid-flight: accept 2 items, assert Rst_n=0 between clock edges -> out_valid=0 and D=0 immediately. After release, in_ready=1 and no stale result ever appears.
